tea_decrypt_scheduler: RTL and testbench

Shares one iterative TEA decryption engine between two requesters. Each requester presents a 128-bit key and a 64-bit cipher block with a valid/ready handshake. The scheduler grants the requesters round-robin and runs one TEA decryption round per clock. It then holds the 64-bit plaintext and the requester tag on a valid/ready result port until the result is consumed. It replaces the fully unrolled combinational decryptor wherever area matters more than throughput.

---
 rtl/tea_pkg.sv | 29 ++
 rtl/tea_round.sv | 27 ++
 rtl/tea_decrypt_scheduler.sv | 137 +++++++++++++
 tb/tb_tea_decrypt_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared TEA constants, the scheduler FSM state type and the request bundle type.
// Contents: TEA_DELTA, TEA_ROUNDS_DEFAULT, sum_init(), state_t, tea_req_t.
// Imported by the scheduler top; the round datapath needs none of it.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA          = 32'h9E3779B9;
  localparam int          TEA_ROUNDS_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One requester's offer: the key and the cipher block it wants decrypted.
  typedef struct packed {
    logic [127:0] key;
    logic [63:0]  cipher;
  } tea_req_t;

  // Starting sum for decryption: the value encryption ends on after `rounds`
  // additions of the delta, wrapped to 32 bits.
  function automatic logic [31:0] sum_init(input int unsigned rounds);
    logic [63:0] prod;
    prod = 64'(rounds) * 64'(TEA_DELTA);
    return prod[31:0];
  endfunction

endpackage

// File: rtl/tea_round.sv
// One TEA decryption round, purely combinational.
// Ports: block1/block2 current halves, sum current round sum, key 128-bit key;
//        block1_next/block2_next halves after the round.
module tea_round (
  input  logic [31:0]  block1,
  input  logic [31:0]  block2,
  input  logic [31:0]  sum,
  input  logic [127:0] key,
  output logic [31:0]  block1_next,
  output logic [31:0]  block2_next
);

  logic [31:0] k0, k1, k2, k3;

  assign k0 = key[127:96];
  assign k1 = key[95:64];
  assign k2 = key[63:32];
  assign k3 = key[31:0];

  // block2 is undone first (it was updated last during encryption), and the
  // block1 update must see the freshly recovered block2.
  always_comb begin
    block2_next = block2 - (((block1 << 4) + k2) ^ (block1 + sum) ^ ((block1 >> 5) + k3));
    block1_next = block1 - (((block2_next << 4) + k0) ^ (block2_next + sum) ^ ((block2_next >> 5) + k1));
  end

endmodule

// File: rtl/tea_decrypt_scheduler.sv
// Two-requester round-robin front end for one iterative TEA decryption engine.
// Ports: in0_*/in1_* valid/ready request ports (key + cipher), out_* valid/ready
//        result port (plaintext + owning requester id), busy = FSM not idle.
module tea_decrypt_scheduler
  import tea_pkg::*;
#(
  parameter int ROUNDS = TEA_ROUNDS_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [127:0] in0_key,
  input  logic [63:0]  in0_cipher,
  input  logic         in1_valid,
  output logic         in1_ready,
  input  logic [127:0] in1_key,
  input  logic [63:0]  in1_cipher,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         out_id,
  output logic         busy
);

  localparam logic [31:0] SUM_INIT = sum_init(ROUNDS);
  localparam logic [5:0]  CNT_LAST = 6'(ROUNDS - 1);

  state_t       state, state_next;
  logic         last;
  logic         id;
  logic [127:0] key;
  logic [31:0]  block1, block2, sum;
  logic [5:0]   cnt;

  logic         grant0, grant1;
  logic         accept;
  logic         sel;
  tea_req_t     req0, req1, req_sel;
  logic [31:0]  block1_next, block2_next;

  assign req0 = '{key: in0_key, cipher: in0_cipher};
  assign req1 = '{key: in1_key, cipher: in1_cipher};

  // Round-robin: a lone valid requester always wins; on contention the one
  // that did not win last time goes next. last resets to 1 so requester 0
  // takes the first contended grant.
  always_comb begin
    grant0 = in0_valid && (!in1_valid || last);
    grant1 = in1_valid && (!in0_valid || !last);
  end

  // Next state and the combinational readys. Only IDLE offers a grant, so
  // the handshake edge out of DONE can never also take a new request.
  always_comb begin
    state_next = state;
    in0_ready  = 1'b0;
    in1_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        in0_ready = grant0;
        in1_ready = grant1;
        if (grant0 || grant1) state_next = RUN;
      end
      RUN: begin
        if (cnt == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A ready is only ever raised towards a valid requester, so ready alone
  // identifies the handshake and the winner.
  assign accept  = in0_ready || in1_ready;
  assign sel     = in1_ready;
  assign req_sel = sel ? req1 : req0;

  tea_round u_round (
    .block1      (block1),
    .block2      (block2),
    .sum         (sum),
    .key         (key),
    .block1_next (block1_next),
    .block2_next (block2_next)
  );

  // Control registers. out_valid and busy are registered copies of the next
  // state so every non-ready output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

  // Datapath. The request is copied in on the accept edge, after which the
  // input ports are ignored until the next grant. In DONE nothing updates,
  // which keeps out_data/out_id stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last   <= 1'b1;
      id     <= 1'b0;
      key    <= '0;
      block1 <= '0;
      block2 <= '0;
      sum    <= '0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        last   <= sel;
        id     <= sel;
        key    <= req_sel.key;
        block1 <= req_sel.cipher[63:32];
        block2 <= req_sel.cipher[31:0];
        sum    <= SUM_INIT;
        cnt    <= '0;
      end
    end else if (state == RUN) begin
      block1 <= block1_next;
      block2 <= block2_next;
      sum    <= sum - TEA_DELTA;
      cnt    <= cnt + 6'd1;
    end
  end

  assign out_data = {block1, block2};
  assign out_id   = id;

endmodule

// File: tb/tb_tea_decrypt_scheduler.sv
module tb_tea_decrypt_scheduler;

  localparam int ROUNDS = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in0_valid, in0_ready;
  logic [127:0] in0_key;
  logic [63:0]  in0_cipher;
  logic         in1_valid, in1_ready;
  logic [127:0] in1_key;
  logic [63:0]  in1_cipher;
  logic         out_valid, out_ready;
  logic [63:0]  out_data;
  logic         out_id;
  logic         busy;

  tea_decrypt_scheduler #(.ROUNDS(ROUNDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in0_valid  (in0_valid),
    .in0_ready  (in0_ready),
    .in0_key    (in0_key),
    .in0_cipher (in0_cipher),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in1_key    (in1_key),
    .in1_cipher (in1_cipher),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [63:0]  cipher;
    logic [63:0]  exp;
  } job_t;

  typedef struct {
    logic [63:0] data;
    logic        id;
  } res_t;

  job_t jobs0[$];
  job_t jobs1[$];
  res_t sb[$];
  int   grant_log[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc0     = 0;
  int acc1     = 0;
  int n_out    = 0;
  int acc_cyc  = 0;
  int or_mode  = 0;
  bit rand_valid = 0;

  // Reference model: textbook TEA decryption with k[0..3] = key words MSW first.
  function automatic logic [63:0] tea_dec(input logic [127:0] k, input logic [63:0] c);
    logic [31:0] v0, v1, s, d;
    logic [31:0] kw [4];
    d = 32'h9E3779B9;
    kw[0] = k[127:96]; kw[1] = k[95:64]; kw[2] = k[63:32]; kw[3] = k[31:0];
    v0 = c[63:32];
    v1 = c[31:0];
    s  = 32'(ROUNDS) * d;
    for (int i = 0; i < ROUNDS; i++) begin
      v1 = v1 - (((v0 << 4) + kw[2]) ^ (v0 + s) ^ ((v0 >> 5) + kw[3]));
      v0 = v0 - (((v1 << 4) + kw[0]) ^ (v1 + s) ^ ((v1 >> 5) + kw[1]));
      s  = s - d;
    end
    return {v0, v1};
  endfunction

  function automatic job_t mk_job(input logic [127:0] k, input logic [63:0] c);
    job_t j;
    j.key = k; j.cipher = c; j.exp = tea_dec(k, c);
    return j;
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus driver: presents the next unaccepted job of each requester; while
  // not offering, the request lines carry fresh garbage every cycle.
  always @(posedge clk) begin
    #1;
    if (acc0 < jobs0.size()) begin
      in0_key    = jobs0[acc0].key;
      in0_cipher = jobs0[acc0].cipher;
      in0_valid  = !rand_valid || ($urandom_range(3) != 0);
    end else begin
      in0_valid  = 1'b0;
      in0_key    = {$urandom, $urandom, $urandom, $urandom};
      in0_cipher = {$urandom, $urandom};
    end
    if (acc1 < jobs1.size()) begin
      in1_key    = jobs1[acc1].key;
      in1_cipher = jobs1[acc1].cipher;
      in1_valid  = !rand_valid || ($urandom_range(3) != 0);
    end else begin
      in1_valid  = 1'b0;
      in1_key    = {$urandom, $urandom, $urandom, $urandom};
      in1_cipher = {$urandom, $urandom};
    end
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor / scoreboard, sampling on the falling edge.
  bit          m_busy  = 0;
  bit          last_m  = 1;
  bit          prev_ov = 0;
  logic [63:0] prev_data;
  logic        prev_id;
  bit          exp_r0, exp_r1;
  res_t        r;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_busy  = 0;
      last_m  = 1;
      prev_ov = 0;
    end else begin
      exp_r0 = !m_busy && in0_valid && (!in1_valid || last_m);
      exp_r1 = !m_busy && in1_valid && (!in0_valid || !last_m);
      check(in0_ready == exp_r0, "in0_ready", 64'(in0_ready), 64'(exp_r0));
      check(in1_ready == exp_r1, "in1_ready", 64'(in1_ready), 64'(exp_r1));
      check(busy == m_busy, "busy", 64'(busy), 64'(m_busy));

      if (out_valid) begin
        if (!prev_ov) begin
          check(cyc - acc_cyc == ROUNDS + 1, "latency", 64'(cyc - acc_cyc), 64'(ROUNDS + 1));
        end else begin
          check(out_data == prev_data, "hold_data", out_data, prev_data);
          check(out_id == prev_id, "hold_id", 64'(out_id), 64'(prev_id));
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            check(1'b0, "unexpected_out", out_data, 64'd0);
          end else begin
            r = sb.pop_front();
            check(out_data == r.data, "out_data", out_data, r.data);
            check(out_id == r.id, "out_id", 64'(out_id), 64'(r.id));
          end
          n_out++;
          m_busy = 0;
        end
      end
      prev_ov   = out_valid && !out_ready;
      prev_data = out_data;
      prev_id   = out_id;

      if (in0_valid && in0_ready && acc0 < jobs0.size()) begin
        sb.push_back('{data: jobs0[acc0].exp, id: 1'b0});
        acc0++;
        last_m  = 0;
        m_busy  = 1;
        acc_cyc = cyc;
        grant_log.push_back(0);
      end else if (in1_valid && in1_ready && acc1 < jobs1.size()) begin
        sb.push_back('{data: jobs1[acc1].exp, id: 1'b1});
        acc1++;
        last_m  = 1;
        m_busy  = 1;
        acc_cyc = cyc;
        grant_log.push_back(1);
      end
    end
  end

  task automatic wait_drain(input int budget, input string name);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      done = (acc0 == jobs0.size()) && (acc1 == jobs1.size()) && (sb.size() == 0) && !busy;
    end
    check(done, name, 64'(done), 64'd1);
  endtask

  int glog_base;
  int out_base;
  int exp_order [4];
  bit seen;

  initial begin
    rst = 1'b1;
    in0_valid = 0; in1_valid = 0; out_ready = 0;
    in0_key = '0; in1_key = '0; in0_cipher = '0; in1_cipher = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
    check(out_data == 64'd0, "rst_out_data", out_data, 64'd0);
    check(out_id == 1'b0, "rst_out_id", 64'(out_id), 64'd0);
    check(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    check(in0_ready == 1'b0, "rst_in0_ready", 64'(in0_ready), 64'd0);
    check(in1_ready == 1'b0, "rst_in1_ready", 64'(in1_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Known answer: all-zero key, cipher of the all-zero plaintext.
    jobs0.push_back('{key: 128'h0, cipher: 64'h41EA3A0A94BAA940, exp: 64'h0});
    wait_drain(200, "kat_drain");

    // Contention from reset: both requesters offer two blocks each.
    @(posedge clk); #1 rst = 1'b1;
    glog_base = grant_log.size();
    for (int i = 0; i < 2; i++) begin
      jobs0.push_back(mk_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}));
      jobs1.push_back(mk_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}));
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_drain(400, "contention_drain");
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    for (int i = 0; i < 4; i++) begin
      if (glog_base + i < grant_log.size())
        check(grant_log[glog_base + i] == exp_order[i], "grant_order", 64'(grant_log[glog_base + i]), 64'(exp_order[i]));
      else
        check(1'b0, "grant_order_missing", 64'(i), 64'(exp_order[i]));
    end

    // Backpressure: result held in DONE with requester 1 waiting.
    @(negedge clk);
    or_mode = 2;
    jobs0.push_back(mk_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}));
    jobs1.push_back(mk_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}));
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check(seen, "bp_out_valid", 64'(seen), 64'd1);
    repeat (10) @(negedge clk);
    or_mode = 0;
    wait_drain(200, "bp_drain");

    // Reset in the middle of RUN: the block vanishes, the next one is correct.
    jobs0.push_back(mk_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}));
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    check(seen, "mid_accept", 64'(seen), 64'd1);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    jobs0.push_back(mk_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}));
    wait_drain(200, "post_rst_drain");

    // Input isolation: the request lines churn every cycle after acceptance.
    jobs0.push_back(mk_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}));
    wait_drain(200, "iso_drain");

    // Randomised traffic.
    @(negedge clk);
    rand_valid = 1;
    or_mode    = 1;
    out_base   = n_out;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(1) == 0)
        jobs0.push_back(mk_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}));
      else
        jobs1.push_back(mk_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}));
    end
    wait_drain(60000, "rand_drain");
    check(n_out - out_base == 1000, "rand_count", 64'(n_out - out_base), 64'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
